// File: rtl/riscv_prog_loader.sv
`default_nettype none
// ============================================================================
// Module   : riscv_prog_loader
// Purpose  : Packs a byte-serial boot image into 32-bit instruction-memory
//            words and holds the core in reset until the image is written.
//            Optional trailer-checksum check: RISCV_PROG_LOADER_CHECKSUM_EN
// Revision : 1.0 - initial release
// ============================================================================
module riscv_prog_loader #(
  parameter int ADDR_W    = 10,
  parameter int MAX_WORDS = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              core_hold,
  output logic              load_done,
  output logic              load_err
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LEN0  = 3'd1,
    S_LEN1  = 3'd2,
    S_DATA  = 3'd3,
    S_FLUSH = 3'd4,
    S_RUN   = 3'd5,
`ifdef RISCV_PROG_LOADER_CHECKSUM_EN
    S_ERROR = 3'd6,
    S_CHK   = 3'd7
`else
    S_ERROR = 3'd6
`endif
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [15:0]       r_len;
  logic [ADDR_W:0]   r_widx;
  logic [1:0]        r_bidx;
  logic [23:0]       r_part;
`ifdef RISCV_PROG_LOADER_CHECKSUM_EN
  logic [7:0]        r_xor;
`endif

  logic              w_acc;
  logic [15:0]       w_len;
  logic              w_len_bad;
  logic              w_last_word;

  assign w_acc     = byte_valid & byte_ready;
  assign w_len     = {byte_data, r_len[7:0]};
  assign w_len_bad = (w_len == 16'd0) || ({16'd0, w_len} > 32'(MAX_WORDS));
  // Index is one bit wider than the address so a full-size image compares cleanly.
  assign w_last_word = (({{(31-ADDR_W){1'b0}}, r_widx} + 32'd1) == {16'd0, r_len});

  always_comb begin
    byte_ready = 1'b0;
    case (r_state)
      S_LEN0, S_LEN1, S_DATA: byte_ready = 1'b1;
`ifdef RISCV_PROG_LOADER_CHECKSUM_EN
      S_CHK:                  byte_ready = 1'b1;
`endif
      default:                byte_ready = 1'b0;
    endcase
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_RUN, S_ERROR: if (ld_start) w_next = S_LEN0;
      S_LEN0:  if (w_acc) w_next = S_LEN1;
      S_LEN1:  if (w_acc) w_next = w_len_bad ? S_ERROR : S_DATA;
      S_DATA: begin
        if (w_acc && (r_bidx == 2'd3) && w_last_word) begin
`ifdef RISCV_PROG_LOADER_CHECKSUM_EN
          w_next = S_CHK;
`else
          w_next = S_FLUSH;
`endif
        end
      end
      S_FLUSH: w_next = S_RUN;
`ifdef RISCV_PROG_LOADER_CHECKSUM_EN
      S_CHK:   if (w_acc) w_next = (byte_data == r_xor) ? S_RUN : S_ERROR;
`endif
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_len      <= '0;
      r_widx     <= '0;
      r_bidx     <= '0;
      r_part     <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      core_hold  <= 1'b1;
      load_done  <= 1'b0;
      load_err   <= 1'b0;
`ifdef RISCV_PROG_LOADER_CHECKSUM_EN
      r_xor      <= '0;
`endif
    end else begin
      imem_we   <= 1'b0;
      core_hold <= (w_next != S_RUN);
      load_done <= (w_next == S_RUN);
      load_err  <= (w_next == S_ERROR);
`ifdef RISCV_PROG_LOADER_CHECKSUM_EN
      if ((w_next == S_LEN0) && (r_state != S_LEN0)) r_xor <= '0;
      else if ((r_state == S_DATA) && w_acc)         r_xor <= r_xor ^ byte_data;
`endif
      case (r_state)
        S_LEN0: if (w_acc) r_len[7:0] <= byte_data;
        S_LEN1: begin
          if (w_acc) begin
            r_len[15:8] <= byte_data;
            r_widx      <= '0;
            r_bidx      <= '0;
          end
        end
        S_DATA: begin
          if (w_acc) begin
            r_bidx <= r_bidx + 2'd1;
            case (r_bidx)
              2'd0: r_part[7:0]   <= byte_data;
              2'd1: r_part[15:8]  <= byte_data;
              2'd2: r_part[23:16] <= byte_data;
              default: begin
                imem_we    <= 1'b1;
                imem_addr  <= r_widx[ADDR_W-1:0];
                imem_wdata <= {byte_data, r_part};
                r_widx     <= r_widx + 1'b1;
              end
            endcase
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_riscv_prog_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_riscv_prog_loader
// Purpose  : Scoreboard bench for riscv_prog_loader (directed + random images).
// Revision : 1.0 - initial release
// ============================================================================
module tb_riscv_prog_loader;
  localparam int ADDR_W    = 10;
  localparam int MAX_WORDS = 1024;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              ld_start = 1'b0;
  logic              byte_valid = 1'b0;
  logic [7:0]        byte_data = 8'h00;
  logic              byte_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              core_hold;
  logic              load_done;
  logic              load_err;

  riscv_prog_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(MAX_WORDS)) dut (
    .clk(clk), .rst(rst), .ld_start(ld_start), .byte_valid(byte_valid),
    .byte_data(byte_data), .byte_ready(byte_ready), .imem_we(imem_we),
    .imem_addr(imem_addr), .imem_wdata(imem_wdata), .core_hold(core_hold),
    .load_done(load_done), .load_err(load_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int unsigned exp_addr[$];
  logic [31:0] exp_data[$];
  logic [31:0] img[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Scoreboard monitor: every write strobe must match the oldest expected word.
  always @(negedge clk) begin
    if (rst && imem_we === 1'b1) begin
      if (exp_addr.size() == 0) begin
        n_checks++;
        $display("FAIL stray_write: got addr %0h data %0h expected no write", imem_addr, imem_wdata);
      end else begin
        chk("write_addr", 32'(imem_addr), exp_addr.pop_front());
        chk("write_data", imem_wdata, exp_data.pop_front());
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    int guard;
    repeat (gap) begin byte_valid = 1'b0; @(negedge clk); end
    byte_valid = 1'b1;
    byte_data  = b;
    guard = 0;
    while (byte_ready !== 1'b1 && guard < 100) begin @(negedge clk); guard++; end
    if (byte_ready !== 1'b1) begin
      n_checks++;
      $display("FAIL byte_timeout: got byte_ready=%0b expected 1 within 100 cycles", byte_ready);
    end
    @(negedge clk);
  endtask

  task automatic pulse_start();
    ld_start = 1'b1;
    @(negedge clk);
    ld_start = 1'b0;
    chk("hold_after_start", {31'd0, core_hold}, 32'd1);
    chk("done_after_start", {31'd0, load_done}, 32'd0);
    chk("err_after_start",  {31'd0, load_err},  32'd0);
  endtask

  // Loads the image in img[]; bytes are serialised from the words LSB first.
  task automatic run_load(input int gmin, input int gmax, input bit noise, input bit good);
    int n;
    logic [7:0] b;
    logic [7:0] x;
    n = img.size();
    x = 8'h00;
    pulse_start();
    for (int i = 0; i < n; i++) begin
      exp_addr.push_back(i);
      exp_data.push_back(img[i]);
    end
    send_byte(8'(n), $urandom_range(gmax, gmin));
    send_byte(8'(n >> 8), $urandom_range(gmax, gmin));
    for (int i = 0; i < n; i++) begin
      for (int k = 0; k < 4; k++) begin
        b = 8'((img[i] / (32'd1 << (8 * k))) % 256);
        x = x ^ b;
        ld_start = noise && ($urandom_range(0, 3) == 0);
        send_byte(b, $urandom_range(gmax, gmin));
      end
    end
    ld_start = 1'b0;
`ifdef RISCV_PROG_LOADER_CHECKSUM_EN
    send_byte(good ? x : (x ^ 8'h01), 0);
    byte_valid = 1'b0;
`else
    byte_valid = 1'b0;
    chk("hold_in_flush", {31'd0, core_hold}, 32'd1);
    @(negedge clk);
`endif
    chk("done_after_load", {31'd0, load_done},  {31'd0, good});
    chk("hold_after_load", {31'd0, core_hold},  {31'd0, !good});
    chk("err_after_load",  {31'd0, load_err},   {31'd0, !good});
    chk("ready_after_load", {31'd0, byte_ready}, 32'd0);
    chk("pending_writes", 32'(exp_addr.size()), 32'd0);
  endtask

  task automatic bad_len(input logic [7:0] lo, input logic [7:0] hi);
    pulse_start();
    send_byte(lo, 0);
    send_byte(hi, 0);
    repeat (3) @(negedge clk);
    byte_valid = 1'b0;
    chk("badlen_err",   {31'd0, load_err},   32'd1);
    chk("badlen_ready", {31'd0, byte_ready}, 32'd0);
    chk("badlen_hold",  {31'd0, core_hold},  32'd1);
    chk("badlen_done",  {31'd0, load_done},  32'd0);
  endtask

  task automatic check_reset_values();
    chk("rst_ready", {31'd0, byte_ready}, 32'd0);
    chk("rst_we",    {31'd0, imem_we},    32'd0);
    chk("rst_addr",  32'(imem_addr),      32'd0);
    chk("rst_wdata", imem_wdata,          32'd0);
    chk("rst_hold",  {31'd0, core_hold},  32'd1);
    chk("rst_done",  {31'd0, load_done},  32'd0);
    chk("rst_err",   {31'd0, load_err},   32'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    check_reset_values();
    rst = 1'b1;
    @(negedge clk);

    img = '{32'h00500013, 32'h00A00093};
    run_load(0, 0, 1'b0, 1'b1);
    img = '{32'h00500013, 32'h00A00093};
    run_load(1, 1, 1'b0, 1'b1);

    img = '{32'h00000073};
    run_load(0, 0, 1'b0, 1'b1);

    bad_len(8'h00, 8'h00);
    bad_len(8'h01, 8'h04);

    img = '{32'hDEADBEEF};
    run_load(0, 0, 1'b0, 1'b1);
    pulse_start();
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 0);
    byte_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    check_reset_values();
    rst = 1'b1;
    @(negedge clk);
    img = '{32'h12345678};
    run_load(0, 0, 1'b0, 1'b1);

    for (int t = 0; t < 8; t++) begin
      img.delete();
      for (int i = 0; i < int'($urandom_range(1, 9)); i++) img.push_back($urandom);
      run_load(0, $urandom_range(0, 2), 1'b1, 1'b1);
    end

    img.delete();
    for (int i = 0; i < MAX_WORDS; i++) img.push_back($urandom);
    run_load(0, 0, 1'b0, 1'b1);

`ifdef RISCV_PROG_LOADER_CHECKSUM_EN
    img = '{32'h00500013};
    run_load(0, 0, 1'b0, 1'b1);
    img = '{32'h00500013};
    run_load(0, 0, 1'b0, 1'b0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
